// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS core: shadows each destination register and its Tnew through E/M/W,
// and from those produces the stall and the D/E/M forwarding selects. Define MDU_HAZARD_EN to add multiply/divide busy stalls.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a3_d,
    input  logic [1:0] tnew_d,
    input  logic       md_use_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    logic [4:0] e_rs_q, e_rt_q, e_a3_q, e_rs_d, e_rt_d, e_a3_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] m_rt_q, m_a3_q, m_rt_d, m_a3_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_a3_q, w_a3_d;
    logic       stall_reg;
    logic       stall_md;

    // $0 is hard-wired, so a producer writing it never satisfies a reader.
    function automatic logic hits(input logic [4:0] a3, input logic [4:0] src);
        return (a3 != 5'd0) && (a3 == src);
    endfunction

    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] ea3, input logic [1:0] etn,
                                       input logic [4:0] ma3, input logic [1:0] mtn);
        return (hits(ea3, src) && (tuse < etn)) || (hits(ma3, src) && (tuse < mtn));
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [4:0] src,
                                             input logic [4:0] ea3, input logic [1:0] etn,
                                             input logic [4:0] ma3, input logic [1:0] mtn,
                                             input logic [4:0] wa3);
        if (hits(ea3, src) && (etn == 2'd0)) return 2'd1;
        if (hits(ma3, src) && (mtn == 2'd0)) return 2'd2;
        if (hits(wa3, src))                  return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src,
                                             input logic [4:0] ma3, input logic [1:0] mtn,
                                             input logic [4:0] wa3);
        if (hits(ma3, src) && (mtn == 2'd0)) return 2'd1;
        if (hits(wa3, src))                  return 2'd2;
        return 2'd0;
    endfunction

`ifdef MDU_HAZARD_EN
    logic       e_md_start_q, e_md_div_q, e_md_start_d, e_md_div_d;
    logic [3:0] busy_q, busy_d;

    // The counter loads as the start leaves E, so the start's own E cycle stalls on top of the busy window.
    always_comb begin
        busy_d = (busy_q != 4'd0) ? busy_q - 4'd1 : 4'd0;
        if (e_md_start_q) busy_d = e_md_div_q ? 4'd10 : 4'd5;
        e_md_start_d = stall ? 1'b0 : md_start_d;
        e_md_div_d   = stall ? 1'b0 : md_div_d;
        stall_md     = md_use_d && ((busy_q != 4'd0) || e_md_start_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            busy_q       <= 4'd0;
        end else begin
            e_md_start_q <= e_md_start_d;
            e_md_div_q   <= e_md_div_d;
            busy_q       <= busy_d;
        end
    end
`else
    logic unused_md;
    assign unused_md = ^{md_use_d, md_start_d, md_div_d};
    assign stall_md  = 1'b0;
`endif

    always_comb begin
        stall_reg = src_stall(rs_d, tuse_rs_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q)
                  | src_stall(rt_d, tuse_rt_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
        stall     = stall_reg | stall_md;
        fwd_d_rs  = fwd_d_sel(rs_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_d_rt  = fwd_d_sel(rt_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_e_rs  = fwd_e_sel(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_e_rt  = fwd_e_sel(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_m_rt  = hits(w_a3_q, m_rt_q);
    end

    // M stores Tnew already decremented, so its compare needs no further adjustment.
    always_comb begin
        e_rs_d   = stall ? 5'd0 : rs_d;
        e_rt_d   = stall ? 5'd0 : rt_d;
        e_a3_d   = stall ? 5'd0 : a3_d;
        e_tnew_d = stall ? 2'd0 : tnew_d;
        m_rt_d   = e_rt_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q != 2'd0) ? e_tnew_q - 2'd1 : 2'd0;
        w_a3_d   = m_a3_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            e_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_rt_q   <= 5'd0;
            m_a3_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            w_a3_q   <= 5'd0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_rt_q   <= m_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, randomized run against an age-based pipeline model, MDU stall counts.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, a3_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       md_use_d, md_start_d, md_div_d;
    logic       stall, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .a3_d(a3_d), .tnew_d(tnew_d),
        .md_use_d(md_use_d), .md_start_d(md_start_d), .md_div_d(md_div_d),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    nm;
        logic     rst;
        int       rs, rt, tur, tut, a3, tn;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        int rs, rt, a3, tnew;
    } inst_t;

    vec_t  tbl[$];
    inst_t pipe[3];

    function automatic logic [9:0] ex(input int st, input int fdrs, input int fdrt,
                                      input int fers, input int fert, input int fmrt);
        return {st[0], fdrs[1:0], fdrt[1:0], fers[1:0], fert[1:0], fmrt[0]};
    endfunction

    task automatic row(input string nm, input logic r, input int rs, input int rt, input int tur,
                       input int tut, input int a3, input int tn, input logic [9:0] e);
        vec_t v;
        v.nm = nm; v.rst = r; v.rs = rs; v.rt = rt; v.tur = tur; v.tut = tut;
        v.a3 = a3; v.tn = tn; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input int rs, input int rt, input int tur, input int tut,
                         input int a3, input int tn, input logic mu, input logic ms, input logic mdv);
        reset      = r;
        rs_d       = rs[4:0];
        rt_d       = rt[4:0];
        tuse_rs_d  = tur[1:0];
        tuse_rt_d  = tut[1:0];
        a3_d       = a3[4:0];
        tnew_d     = tn[1:0];
        md_use_d   = mu;
        md_start_d = ms;
        md_div_d   = mdv;
    endtask

    function automatic logic [9:0] act();
        return {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt};
    endfunction

    task automatic check(input string nm, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got stall/fdrs/fdrt/fers/fert/fmrt=%b want %b", nm, got, want);
        end
    endtask

    // Reference model: each in-flight instruction keeps its original Tnew; remaining time is Tnew minus stage age.
    function automatic int rem(input int k);
        return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
    endfunction

    function automatic logic hit(input int k, input int src);
        return (src != 0) && (pipe[k].a3 == src);
    endfunction

    function automatic logic [9:0] model(input int rs, input int rt, input int tur, input int tut);
        int st, fd[2], fe[2], fm, src[2], tu[2];
        src[0] = rs; src[1] = rt; tu[0] = tur; tu[1] = tut;
        st = 0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 2; k++)
                if (hit(k, src[s]) && tu[s] < rem(k)) st = 1;
            fd[s] = 0;
            for (int k = 2; k >= 0; k--)
                if (hit(k, src[s]) && rem(k) == 0) fd[s] = k + 1;
        end
        src[0] = pipe[0].rs; src[1] = pipe[0].rt;
        for (int s = 0; s < 2; s++) begin
            fe[s] = 0;
            for (int k = 2; k >= 1; k--)
                if (hit(k, src[s]) && rem(k) == 0) fe[s] = k;
        end
        fm = hit(2, pipe[1].rt) ? 1 : 0;
        return ex(st, fd[0], fd[1], fe[0], fe[1], fm);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
    endtask

    int n_stall, exp_div, exp_mul;

    task automatic mdu_seq(input logic is_div, input int want, input string nm);
        @(posedge clk); #1; drive(1'b1, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; drive(1'b0, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; drive(1'b0, 8, 9, 1, 1, 0, 0, 1'b1, 1'b1, is_div);
        @(negedge clk);
        check({nm, "_issue"}, {9'd0, stall}, 10'd0);
        @(posedge clk); #1; drive(1'b0, 0, 0, 3, 3, 10, 1, 1'b1, 1'b0, 1'b0);
        n_stall = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            @(posedge clk); #1;
        end
        total++;
        if (n_stall != want) begin
            bad++;
            $display("FAIL %s_stall_cycles: got %0d want %0d", nm, n_stall, want);
        end
    endtask

    initial begin
        drive(1'b1, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);

        row("reset_held",      1, 0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
        row("lw8_issue",       0, 4, 8, 1, 3, 8, 2, ex(0,0,0,0,0,0));
        row("add_loaduse_stl", 0, 8, 8, 1, 1, 9, 1, ex(1,0,0,0,0,0));
        row("add_released",    0, 8, 8, 1, 1, 9, 1, ex(0,0,0,0,0,0));
        row("add_fwd_e_w",     0, 0, 0, 3, 3, 0, 0, ex(0,0,0,2,2,0));
        row("lw8_again",       0, 4, 8, 1, 3, 8, 2, ex(0,0,0,0,0,0));
        row("reset_midstream", 1, 8, 8, 1, 1, 9, 1, ex(0,0,0,0,0,0));
        row("after_release",   0, 8, 8, 1, 1, 9, 1, ex(0,0,0,0,0,0));
        row("addu8",           0, 1, 2, 1, 1, 8, 1, ex(0,0,0,0,0,0));
        row("beq_stall",       0, 8, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0));
        row("beq_fwd_d_m",     0, 8, 0, 0, 0, 0, 0, ex(0,2,0,0,0,0));
        row("addu8_b",         0, 1, 2, 1, 1, 8, 1, ex(0,0,0,2,0,0));
        row("nop_gap",         0, 0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
        row("beq_gap_fwd_m",   0, 8, 0, 0, 0, 0, 0, ex(0,2,0,0,0,0));
        row("write_r0",        0, 3, 3, 1, 1, 0, 2, ex(0,0,0,2,0,0));
        row("read_r0",         0, 0, 0, 0, 0, 5, 1, ex(0,0,0,0,0,0));
        row("addu8_p1",        0, 1, 2, 1, 1, 8, 1, ex(0,0,0,0,0,0));
        row("addu8_p2",        0, 3, 4, 1, 1, 8, 1, ex(0,0,0,0,0,0));
        row("sw8_d",           0, 4, 8, 1, 2, 0, 0, ex(0,0,2,0,0,0));
        row("sw8_e_nearest",   0, 0, 0, 3, 3, 0, 0, ex(0,0,0,0,1,0));
        row("sw8_m_fwd_w",     0, 0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,1));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].tur, tbl[i].tut, tbl[i].a3, tbl[i].tn,
                  1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check(tbl[i].nm, act(), tbl[i].exp);
        end

        begin
            int c_rst, c_rs, c_rt, c_tur, c_tut, c_a3, c_tn;
            logic [9:0] want;
            c_rst = 1; c_rs = 0; c_rt = 0; c_tur = 3; c_tut = 3; c_a3 = 0; c_tn = 0;
            want = '0;
            clear_model();
            for (int n = 0; n < 400; n++) begin
                @(posedge clk);
                if (c_rst != 0) clear_model();
                else begin
                    pipe[2] = pipe[1];
                    pipe[1] = pipe[0];
                    if (want[9]) pipe[0] = '{0, 0, 0, 0};
                    else         pipe[0] = '{c_rs, c_rt, c_a3, c_tn};
                end
                #1;
                c_rst = ($urandom_range(0, 49) == 0) ? 1 : 0;
                c_rs  = $urandom_range(0, 3);
                c_rt  = $urandom_range(0, 3);
                c_tur = $urandom_range(0, 3);
                c_tut = $urandom_range(0, 3);
                c_a3  = $urandom_range(0, 3);
                c_tn  = $urandom_range(0, 2);
                drive(c_rst[0], c_rs, c_rt, c_tur, c_tut, c_a3, c_tn, 1'b0, 1'b0, 1'b0);
                if (c_rst != 0) clear_model();
                want = model(c_rs, c_rt, c_tur, c_tut);
                @(negedge clk);
                check($sformatf("rand_%0d", n), act(), want);
            end
        end

`ifdef MDU_HAZARD_EN
        exp_div = 11;
        exp_mul = 6;
`else
        exp_div = 0;
        exp_mul = 0;
`endif
        mdu_seq(1'b1, exp_div, "div_mfhi");
        mdu_seq(1'b0, exp_mul, "mult_mfhi");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
